// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: stall vectors,
// controller state encoding and the stall-request priority helper.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE    = 6'b000000;
  localparam stall_bus_t STALL_FROM_ID = 6'b000111;
  localparam stall_bus_t STALL_FROM_EX = 6'b001111;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_MULTI = 1'b1
  } ctrl_state_e;

  // Execute hazards freeze one stage deeper than decode load-use stalls.
  function automatic stall_bus_t req_stall(input logic ex_req, input logic id_req);
    if (ex_req)
      return STALL_FROM_EX;
    else if (id_req)
      return STALL_FROM_ID;
    return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> sequencer signal bundle. The pipeline side is the master
// (raises requests), the sequencer is the slave (returns stall/flush control).
interface pipe_ctrl_if #(
  parameter int MC_LEN_W = 5,
  parameter int PERF_W   = 32
) ();

  logic                       stallreq_id;
  logic                       stallreq_ex;
  logic                       mc_start;
  logic [MC_LEN_W-1:0]        mc_len;
  logic                       flush_req;
  logic [31:0]                flush_pc;
  pipe_ctrl_pkg::stall_bus_t  stall;
  logic                       flush;
  logic [31:0]                new_pc;
  logic                       mc_done;
  logic                       mc_abort;
  logic                       busy;
  logic [PERF_W-1:0]          stall_cycles;
  logic                       stall_timeout;

  modport master (
    output stallreq_id, stallreq_ex, mc_start, mc_len, flush_req, flush_pc,
    input  stall, flush, new_pc, mc_done, mc_abort, busy, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mc_start, mc_len, flush_req, flush_pc,
    output stall, flush, new_pc, mc_done, mc_abort, busy, stall_cycles, stall_timeout
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clr has priority over inc.
module pipe_ctrl_sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != MAX))
      cnt <= cnt + WIDTH'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vectors, multi-cycle execute sequencing,
// flush/redirect, saturating stall-cycle counter and sticky stall watchdog.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   CTRL_RUN   | normal issue; stall from ex/id requests or mc_start
//   CTRL_MULTI | multi-cycle op in flight; mc_cnt cycles left before done
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = 5,
  parameter int TIMEOUT  = 1024,
  parameter int PERF_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int CONSEC_W = $clog2(TIMEOUT + 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(TIMEOUT - 1);

  ctrl_state_e         state_q, state_d;
  logic [MC_LEN_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [MC_LEN_W-1:0] eff_len;
  stall_bus_t          stall;
  logic                flush;
  logic [31:0]         new_pc;
  logic                mc_done;
  logic                mc_abort;
  logic [CONSEC_W-1:0] consec;
  logic                stall_timeout_q;
  logic [PERF_W-1:0]   stall_cycles;

  assign eff_len = (bus.mc_len == '0) ? MC_LEN_W'(1) : bus.mc_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CTRL_RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    if (bus.flush_req) begin
      state_d  = CTRL_RUN;
      mc_cnt_d = '0;
    end else begin
      unique case (state_q)
        CTRL_RUN: begin
          if (bus.mc_start) begin
            state_d  = CTRL_MULTI;
            mc_cnt_d = eff_len - MC_LEN_W'(1);
          end
        end
        CTRL_MULTI: begin
          if (mc_cnt_q != '0)
            mc_cnt_d = mc_cnt_q - MC_LEN_W'(1);
          else
            state_d = CTRL_RUN;
        end
        default: state_d = CTRL_RUN;
      endcase
    end
  end

  // mc_start arriving in the done cycle is deliberately dropped: execute
  // waits for mc_done before issuing again.
  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = '0;
    mc_done  = 1'b0;
    mc_abort = 1'b0;
    if (!rst) begin
      if (bus.flush_req) begin
        flush    = 1'b1;
        new_pc   = bus.flush_pc;
        mc_abort = (state_q == CTRL_MULTI) || bus.mc_start;
      end else begin
        unique case (state_q)
          CTRL_RUN: begin
            if (bus.mc_start)
              stall = STALL_FROM_EX;
            else
              stall = req_stall(bus.stallreq_ex, bus.stallreq_id);
          end
          CTRL_MULTI: begin
            if (mc_cnt_q != '0) begin
              stall = STALL_FROM_EX;
            end else begin
              mc_done = 1'b1;
              stall   = req_stall(bus.stallreq_ex, bus.stallreq_id);
            end
          end
          default: stall = STALL_NONE;
        endcase
      end
    end
  end

  pipe_ctrl_sat_counter #(
    .WIDTH (PERF_W)
  ) u_perf (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .clr (1'b0),
    .cnt (stall_cycles)
  );

  pipe_ctrl_sat_counter #(
    .WIDTH (CONSEC_W),
    .MAX   (CONSEC_MAX)
  ) u_consec (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .clr (!stall[0] || flush),
    .cnt (consec)
  );

  always_ff @(posedge clk) begin
    if (rst)
      stall_timeout_q <= 1'b0;
    else if (stall[0] && (consec == CONSEC_MAX))
      stall_timeout_q <= 1'b1;
  end

  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.mc_done       = mc_done;
  assign bus.mc_abort      = mc_abort;
  assign bus.busy          = (state_q == CTRL_MULTI) && !rst;
  assign bus.stall_cycles  = stall_cycles;
  assign bus.stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall vectors, multi-cycle sequencing,
// flush/abort, watchdog and perf-counter saturation.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.MC_LEN_W(5), .PERF_W(4)) bus ();

  pipe_ctrl #(
    .MC_LEN_W (5),
    .TIMEOUT  (8),
    .PERF_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0;
    bus.mc_start    = 1'b0;
    bus.mc_len      = '0;
    bus.flush_req   = 1'b0;
    bus.flush_pc    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();

    // reset forces combinational outputs even with every request raised
    @(negedge clk);
    bus.stallreq_ex = 1'b1; bus.flush_req = 1'b1; bus.flush_pc = 32'hdead_beef;
    bus.mc_start = 1'b1; bus.mc_len = 5'd3;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    chk("rst_abort", 32'(bus.mc_abort), 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_perf", 32'(bus.stall_cycles), 32'h0);
    chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);
    rst = 1'b0;

    // decode stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.stallreq_id = 1'b1;
      #1 chk("id_stall", 32'(bus.stall), 32'h07);
    end
    @(negedge clk);
    bus.stallreq_id = 1'b0;
    #1;
    chk("id_release", 32'(bus.stall), 32'h0);
    chk("id_perf", 32'(bus.stall_cycles), 32'd3);

    // multi-cycle op, length 4
    @(negedge clk);
    bus.mc_start = 1'b1; bus.mc_len = 5'd4;
    #1;
    chk("mc4_start_stall", 32'(bus.stall), 32'h0f);
    chk("mc4_start_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mc_start = 1'b0;
      #1;
      chk("mc4_stall", 32'(bus.stall), 32'h0f);
      chk("mc4_busy", 32'(bus.busy), 32'h1);
      chk("mc4_no_done", 32'(bus.mc_done), 32'h0);
    end
    @(negedge clk);
    #1;
    chk("mc4_done", 32'(bus.mc_done), 32'h1);
    chk("mc4_done_stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    #1;
    chk("mc4_after_busy", 32'(bus.busy), 32'h0);
    chk("mc4_after_done", 32'(bus.mc_done), 32'h0);

    // zero length behaves as one; done cycle honours a concurrent ex request
    @(negedge clk);
    bus.mc_start = 1'b1; bus.mc_len = 5'd0;
    #1 chk("mc0_stall", 32'(bus.stall), 32'h0f);
    @(negedge clk);
    bus.mc_start = 1'b0; bus.stallreq_ex = 1'b1;
    #1;
    chk("mc0_busy", 32'(bus.busy), 32'h1);
    chk("mc0_done", 32'(bus.mc_done), 32'h1);
    chk("mc0_done_exstall", 32'(bus.stall), 32'h0f);
    @(negedge clk);
    bus.stallreq_ex = 1'b0;
    #1;
    chk("mc0_after_busy", 32'(bus.busy), 32'h0);
    chk("mc0_after_done", 32'(bus.mc_done), 32'h0);

    // flush on the 3rd MULTI cycle of a length-6 op
    @(negedge clk);
    bus.mc_start = 1'b1; bus.mc_len = 5'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.mc_start = 1'b0;
      #1 chk("mc6_busy", 32'(bus.busy), 32'h1);
    end
    @(negedge clk);
    bus.flush_req = 1'b1; bus.flush_pc = 32'h0000_0100;
    #1;
    chk("mc6_flush", 32'(bus.flush), 32'h1);
    chk("mc6_new_pc", bus.new_pc, 32'h0000_0100);
    chk("mc6_stall", 32'(bus.stall), 32'h0);
    chk("mc6_abort", 32'(bus.mc_abort), 32'h1);
    chk("mc6_no_done", 32'(bus.mc_done), 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("mc6_after_busy", 32'(bus.busy), 32'h0);
    chk("mc6_after_flush", 32'(bus.flush), 32'h0);
    chk("mc6_after_abort", 32'(bus.mc_abort), 32'h0);

    // flush beats mc_start and stallreq_ex in RUN
    @(negedge clk);
    bus.flush_req = 1'b1; bus.flush_pc = 32'h0000_0200;
    bus.mc_start = 1'b1; bus.mc_len = 5'd3; bus.stallreq_ex = 1'b1;
    #1;
    chk("prio_flush", 32'(bus.flush), 32'h1);
    chk("prio_new_pc", bus.new_pc, 32'h0000_0200);
    chk("prio_stall", 32'(bus.stall), 32'h0);
    chk("prio_abort", 32'(bus.mc_abort), 32'h1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("prio_busy", 32'(bus.busy), 32'h0);
    chk("prio_after_stall", 32'(bus.stall), 32'h0);

    // watchdog: 8 consecutive ex stalls
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.stallreq_ex = 1'b1;
      #1;
      chk("wd_stall", 32'(bus.stall), 32'h0f);
      chk("wd_not_yet", 32'(bus.stall_timeout), 32'h0);
    end
    @(negedge clk);
    bus.stallreq_ex = 1'b0;
    #1;
    chk("wd_set", 32'(bus.stall_timeout), 32'h1);
    chk("wd_perf", 32'(bus.stall_cycles), 32'd8);
    repeat (3) @(negedge clk);
    #1 chk("wd_sticky", 32'(bus.stall_timeout), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("wd_rst_clear", 32'(bus.stall_timeout), 32'h0);
    chk("wd_rst_perf", 32'(bus.stall_cycles), 32'h0);

    // perf counter saturation at 4'hF
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.stallreq_id = 1'b1;
    end
    @(negedge clk);
    #1 chk("perf_14", 32'(bus.stall_cycles), 32'd14);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("perf_sat", 32'(bus.stall_cycles), 32'd15);
    end
    @(negedge clk);
    bus.stallreq_id = 1'b0;
    #1 chk("perf_hold", 32'(bus.stall_cycles), 32'd15);

    // reset in the middle of a multi-cycle op
    @(negedge clk);
    bus.mc_start = 1'b1; bus.mc_len = 5'd5;
    @(negedge clk);
    bus.mc_start = 1'b0; rst = 1'b1;
    #1;
    chk("mcrst_busy", 32'(bus.busy), 32'h0);
    chk("mcrst_done", 32'(bus.mc_done), 32'h0);
    chk("mcrst_abort", 32'(bus.mc_abort), 32'h0);
    chk("mcrst_stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mcrst_after_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    #1;
    chk("mcrst_after_done", 32'(bus.mc_done), 32'h0);
    chk("mcrst_after_stall", 32'(bus.stall), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It turns stall requests from decode (load-use) and execute (hazards, multi-cycle ops) into per-stage stall vectors. It sequences multi-cycle execute operations with an internal down-counter and issues pipeline flushes with a redirect PC. It also keeps a saturating stall-cycle performance counter and a sticky stall-timeout watchdog.

Parameters:
MC_LEN_W, 5, width of multi-cycle length field (max op length 2^MC_LEN_W-1 cycles)
TIMEOUT, 1024, consecutive stalled cycles that set stall_timeout
PERF_W, 32, width of stall-cycle performance counter

Ports:
clk  input  1  core clock
rst  input  1  reset, synchronous, active-high
stallreq_id  input  1  decode stall request (level)
stallreq_ex  input  1  execute stall request (level)
mc_start  input  1  execute issues a multi-cycle op (1-cycle pulse)
mc_len  input  MC_LEN_W  op length in cycles, sampled with mc_start
flush_req  input  1  exception/redirect request (level, sampled each cycle)
flush_pc  input  32  redirect target
stall  output  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
flush  output  1  clear all pipeline registers this cycle
new_pc  output  32  redirect PC, valid when flush=1
mc_done  output  1  1-cycle pulse: multi-cycle op result ready
mc_abort  output  1  1-cycle pulse: multi-cycle op killed by flush
busy  output  1  state==MULTI
stall_cycles  output  PERF_W  saturating count of cycles with stall[0]=1
stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at posedge): state←RUN, mc_cnt←0, stall_cycles←0, consec←0, stall_timeout←0. While rst=1, the combinational outputs are forced: stall=0, flush=0, new_pc=0, mc_done=0, mc_abort=0, busy=0.
- States: RUN, MULTI. stall, flush, new_pc, mc_done and mc_abort are combinational from state, mc_cnt and the inputs. All else is registered.
- Priority each cycle: flush_req > MULTI/mc_start > stallreq_ex > stallreq_id > none.
- flush_req=1, any state:
  - Outputs: flush=1, new_pc=flush_pc, stall=6'b000000.
  - Next state RUN, mc_cnt←0.
  - mc_abort=1 if state==MULTI or mc_start=1 this cycle.
- RUN, mc_start=1:
  - Outputs: stall=6'b001111.
  - Let eff_len = (mc_len==0 ? 1 : mc_len).
  - Registered: mc_cnt←eff_len-1, state←MULTI. Total stalled cycles = eff_len.
- MULTI, mc_cnt!=0: stall=6'b001111, mc_cnt←mc_cnt-1. stallreq_id/stallreq_ex are subsumed, and mc_start is ignored.
- MULTI, mc_cnt==0:
  - Outputs: mc_done=1, stall=0, or the RUN-rule vector if stallreq_ex/stallreq_id is asserted.
  - Next state RUN.
  - mc_start in this cycle is ignored; execute must not re-issue until it has seen mc_done.
- RUN, no mc_start: stallreq_ex → 6'b001111; otherwise stallreq_id → 6'b000111; otherwise 6'b000000.
- Perf counter: +1 per cycle with stall[0]=1; saturates at all-ones and does not wrap.
- Watchdog:
  - consec increments while stall[0]=1 and clears on stall[0]=0 or flush.
  - When consec reaches TIMEOUT-1 with stall[0]=1, set stall_timeout. It clears only on rst.
  - consec saturates at TIMEOUT-1.
- Reset mid-MULTI: returns to RUN with no mc_done or mc_abort pulse.

Decomposition:
- Shared macros.v additions: StallNone 6'b000000, StallFromId 6'b000111, StallFromEx 6'b001111, CtrlRun / CtrlMulti state encodings, StallBus 5:0.
- One natural sub-module, sat_counter (parameterised width, inc, clr, saturating). It is instantiated for stall_cycles and for the watchdog consec counter.

Test Plan:
- stallreq_id=1 for 3 cycles → stall=6'b000111 for exactly those 3 cycles; stall_cycles=3.
- mc_start with mc_len=4 → stall=6'b001111 for 4 cycles, mc_done pulse on the 5th cycle with stall=0. With mc_len=0 → 1 stall cycle, then mc_done.
- mc_len=6 with flush_req=1 and flush_pc=32'h0000_0100 on the 3rd MULTI cycle → flush=1, new_pc=32'h0000_0100, stall=0, mc_abort=1, no mc_done; busy=0 next cycle.
- flush_req, mc_start and stallreq_ex asserted together in RUN → flush=1, stall=0, mc_abort=1, state stays RUN.
- stallreq_ex held for TIMEOUT cycles (TIMEOUT=8 in bench) → stall_timeout=1 after the 8th stalled cycle; it stays set after release and clears only on rst.
- Force stall_cycles to 2^PERF_W-2 (PERF_W=4 in bench), then stall for 5 cycles → counter holds at 4'hF.
